uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses host commands arriving byte-by-byte from a UART
// receiver and answers each terminated command over the UART transmitter.
//   "D<c><h><h>" CR : set PWM duty channel c ('0'-'3') to hex hh
//   "L<h><h>"    CR : set led_cmd to hh[5:0]
// A good command answers "K" LF and a rejected one answers "E" LF.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   rx_data/rx_valid - received byte and its one-cycle strobe
//   tx_busy          - transmitter busy
//   tx_data/tx_valid - response byte and its one-cycle launch strobe
//   duty             - four 8-bit duty values, channel n at [8n+7:8n]
//   led_cmd          - host-commanded LED pattern
//   rx_drop          - one-cycle pulse when a byte is discarded during a response
module uart_cmd_parser #(
  parameter logic [7:0] DUTY_RST = 8'd128,
  parameter logic [5:0] LED_RST  = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic [31:0] duty,
  output logic [5:0]  led_cmd,
  output logic        rx_drop
);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_OK = 8'h4B;
  localparam logic [7:0] CH_ER = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_CH, S_HI, S_LO, S_CR, S_FLUSH, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    TX_SEND, TX_WAIT_BUSY, TX_WAIT_DONE
  } tx_phase_t;

  state_t     state;
  tx_phase_t  tx_phase;
  logic       resp_idx;   // 0: status byte, 1: trailing LF
  logic [7:0] status;
  logic       is_led;
  logic [1:0] chan;
  logic [3:0] nib_hi;
  logic [3:0] nib_lo;

  logic       hex_ok_c;
  logic [3:0] hex_val_c;

  // Hex digit decode of the incoming byte.
  always_comb begin
    hex_ok_c  = 1'b0;
    hex_val_c = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      hex_ok_c  = 1'b1;
      hex_val_c = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      hex_ok_c  = 1'b1;
      hex_val_c = 4'(rx_data - 8'h37);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      hex_ok_c  = 1'b1;
      hex_val_c = 4'(rx_data - 8'h57);
    end
  end

  // Parser, commit and response sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_phase <= TX_SEND;
      resp_idx <= 1'b0;
      status   <= 8'd0;
      is_led   <= 1'b0;
      chan     <= 2'd0;
      nib_hi   <= 4'd0;
      nib_lo   <= 4'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      rx_drop  <= 1'b0;
      duty     <= {4{DUTY_RST}};
      led_cmd  <= LED_RST;
    end else begin
      tx_valid <= 1'b0;
      rx_drop  <= 1'b0;
      case (state)
        S_IDLE: if (rx_valid) begin
          if (rx_data == 8'h44 || rx_data == 8'h64) begin
            is_led <= 1'b0;
            state  <= S_CH;
          end else if (rx_data == 8'h4C || rx_data == 8'h6C) begin
            is_led <= 1'b1;
            state  <= S_HI;
          end else if (rx_data != CH_CR && rx_data != CH_LF) begin
            state <= S_FLUSH;
          end
        end
        S_CH: if (rx_valid) begin
          if (rx_data >= 8'h30 && rx_data <= 8'h33) begin
            chan  <= rx_data[1:0];
            state <= S_HI;
          end else begin
            state <= S_FLUSH;
          end
        end
        S_HI: if (rx_valid) begin
          if (hex_ok_c) begin
            nib_hi <= hex_val_c;
            state  <= S_LO;
          end else begin
            state <= S_FLUSH;
          end
        end
        S_LO: if (rx_valid) begin
          if (hex_ok_c) begin
            nib_lo <= hex_val_c;
            state  <= S_CR;
          end else begin
            state <= S_FLUSH;
          end
        end
        S_CR: if (rx_valid) begin
          if (rx_data == CH_CR) begin
            if (is_led) led_cmd <= {nib_hi[1:0], nib_lo};
            else        duty[{chan, 3'b000} +: 8] <= {nib_hi, nib_lo};
            status   <= CH_OK;
            resp_idx <= 1'b0;
            tx_phase <= TX_SEND;
            state    <= S_RESP;
          end else begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: if (rx_valid && rx_data == CH_CR) begin
          status   <= CH_ER;
          resp_idx <= 1'b0;
          tx_phase <= TX_SEND;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rx_valid) rx_drop <= 1'b1;
          case (tx_phase)
            TX_SEND: if (!tx_busy) begin
              tx_valid <= 1'b1;
              tx_data  <= resp_idx ? CH_LF : status;
              tx_phase <= TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: if (tx_busy) tx_phase <= TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) begin
              if (resp_idx) begin
                state <= S_IDLE;
              end else begin
                resp_idx <= 1'b1;
                tx_phase <= TX_SEND;
              end
            end
            default: tx_phase <= TX_SEND;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a small transmitter model that
// raises tx_busy for a few cycles after each launched byte.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [31:0] duty;
  logic [5:0]  led_cmd;
  logic        rx_drop;

  int tests = 0;
  int fails = 0;

  logic       force_busy = 1'b0;
  logic [3:0] busy_cnt = 4'd0;
  logic       prev_valid = 1'b0;
  int         dbl_valid = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  assign tx_busy = force_busy | (busy_cnt != 4'd0);

  uart_cmd_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .duty(duty), .led_cmd(led_cmd), .rx_drop(rx_drop)
  );

  // Transmitter model: capture launched bytes and stay busy for 4 cycles.
  always @(posedge clk) begin
    prev_valid <= tx_valid;
    if (tx_valid && prev_valid) dbl_valid <= dbl_valid + 1;
    if (tx_valid) begin
      txq.push_back(tx_data);
      busy_cnt <= 4'd4;
    end else if (busy_cnt != 4'd0) begin
      busy_cnt <= busy_cnt - 4'd1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    txq.delete();
  endtask

  task automatic wait_resp(input logic [7:0] st, input string name);
    int n;
    n = 0;
    while (txq.size() < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (txq.size() < 2) begin
      fails++;
      $display("FAIL %s timeout: got %0d bytes, need 2", name, txq.size());
    end else begin
      tests++;
      if (txq[0] !== st) begin
        fails++;
        $display("FAIL %s status: got %h, expected %h", name, txq[0], st);
      end
      if (txq[1] !== 8'h0A) begin
        fails++;
        $display("FAIL %s lf: got %h, expected 0a", name, txq[1]);
      end
    end
    repeat (12) @(negedge clk);
    txq.delete();
  endtask

  task automatic check_duty(input logic [31:0] exp, input string name);
    tests++;
    if (duty !== exp) begin
      fails++;
      $display("FAIL %s duty: got %h, expected %h", name, duty, exp);
    end
  endtask

  task automatic check_led(input logic [5:0] exp, input string name);
    tests++;
    if (led_cmd !== exp) begin
      fails++;
      $display("FAIL %s led_cmd: got %h, expected %h", name, led_cmd, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_duty(32'h80808080, "reset");
    check_led(6'h00, "reset");
    tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_drop !== 1'b0) begin
      fails++;
      $display("FAIL reset outs: got tx_valid=%b tx_data=%h rx_drop=%b, expected 0 00 0",
               tx_valid, tx_data, rx_drop);
    end
  endtask

  task automatic test_duty();
    int lat;
    send_str("D2A5");
    check_duty(32'h80808080, "duty_precr");
    send_byte(8'h0D);
    check_duty(32'h80A58080, "duty_commit");
    lat = 0;
    while (tx_valid !== 1'b1 && lat < 3) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (tx_valid !== 1'b1 || lat > 1) begin
      fails++;
      $display("FAIL duty_latency: got %0d cycles after CR, expected at most 2", lat + 1);
    end
    wait_resp(8'h4B, "duty_resp");
    check_duty(32'h80A58080, "duty_hold");
  endtask

  task automatic test_led();
    send_str("l3f");
    send_byte(8'h0D);
    check_led(6'h3F, "led");
    check_duty(32'h80A58080, "led_duty");
    wait_resp(8'h4B, "led_resp");
  endtask

  task automatic test_bad_channel();
    send_str("D500");
    repeat (10) @(negedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL badch_early: got %0d bytes before CR, expected 0", txq.size());
    end
    send_byte(8'h0D);
    wait_resp(8'h45, "badch_resp");
    check_duty(32'h80A58080, "badch_duty");
  endtask

  task automatic test_bad_hex();
    send_str("D1G0");
    send_byte(8'h0D);
    wait_resp(8'h45, "badhex_resp");
    check_duty(32'h80A58080, "badhex_duty");
  endtask

  task automatic test_busy_hold();
    int nvalid;
    int ndrop;
    force_busy = 1'b1;
    send_str("L01");
    send_byte(8'h0D);
    send_byte(8'h58);
    tests++;
    if (rx_drop !== 1'b1) begin
      fails++;
      $display("FAIL busy_drop: got rx_drop=%b, expected 1", rx_drop);
    end
    nvalid = 0;
    ndrop = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) nvalid++;
      if (rx_drop === 1'b1) ndrop++;
    end
    tests++;
    if (nvalid != 0 || ndrop != 0) begin
      fails++;
      $display("FAIL busy_hold: got tx_valid=%0d rx_drop=%0d extra, expected 0 0", nvalid, ndrop);
    end
    check_led(6'h01, "busy_led");
    force_busy = 1'b0;
    wait_resp(8'h4B, "busy_resp");
  endtask

  task automatic test_reset_mid();
    send_str("D0F");
    do_reset();
    check_duty(32'h80808080, "rstmid");
    check_led(6'h00, "rstmid");
    repeat (30) @(negedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL rstmid_tx: got %0d bytes, expected 0", txq.size());
    end
    send_str("D0FF");
    send_byte(8'h0D);
    check_duty(32'h808080FF, "rstmid_after");
    wait_resp(8'h4B, "rstmid_resp");
  endtask

  task automatic test_back_to_back();
    send_byte(8'h0D);
    send_byte(8'h0A);
    repeat (10) @(negedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL idle_crlf: got %0d bytes, expected 0", txq.size());
    end
    send_str("d3fF");
    send_byte(8'h0D);
    check_duty(32'hFF8080FF, "b2b_duty");
    wait_resp(8'h4B, "b2b_resp");
    send_str("Lc2");
    send_byte(8'h0D);
    check_led(6'h02, "b2b_led");
    wait_resp(8'h4B, "b2b_led_resp");
    tests++;
    if (dbl_valid != 0) begin
      fails++;
      $display("FAIL tx_valid_double: got %0d back-to-back pulses, expected 0", dbl_valid);
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_led();
    test_bad_channel();
    test_bad_hex();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
